// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : Pipeline boundary register (EX/MEM, MEM/WB, ...) with a 2-entry
//             skid buffer. Valid/ready on both sides, full throughput,
//             registered backpressure, synchronous flush, and a control bus
//             that reads zero whenever no valid entry is presented.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous, active-high reset
//             flush      synchronous kill of all held entries
//             in_valid   upstream presents an entry
//             in_ready   stage can accept (transfer on in_valid && in_ready)
//             in_ctrl    control fields from upstream       [CTRL_W]
//             in_data    payload from upstream              [DATA_W]
//             out_valid  entry available downstream
//             out_ready  downstream accepts (pop on out_valid && out_ready)
//             out_ctrl   control to downstream, zero on bubbles [CTRL_W]
//             out_data   payload to downstream              [DATA_W]
//             occupancy  number of held entries (0..2)
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 3,
    parameter int ZERO_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // State encoding equals the number of held entries, so occupancy is
    // simply the state register.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam bit c_CLEAR_DATA = (ZERO_DATA != 0);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_live;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_push;
    logic              w_pop;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;
    logic              w_clear_main;

    // r_live is cleared asynchronously by rst and set on the first edge after
    // release, so in_ready is low for the whole reset window and rises only
    // once the stage has been clocked out of reset.
    assign in_ready  = r_live && !flush && (r_state != S_TWO);
    assign out_valid = (r_state != S_EMPTY);
    assign occupancy = r_state;

    // The main control register is cleared whenever the stage drains or is
    // flushed, so out_ctrl is a pure register output that is zero on bubbles.
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;

    // flush gates in_ready, so no entry is ever captured in a flush cycle.
    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath-enable decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clear_main     = 1'b0;

        if (flush) begin
            w_state_nxt  = S_EMPTY;
            w_clear_main = 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt    = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_push && !w_pop) begin
                        // Downstream stalled: park the new entry in the skid.
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_push && w_pop) begin
                        w_load_main_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt  = S_EMPTY;
                        w_clear_main = 1'b1;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a pop can occur.
                    if (w_pop) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean empty stage.
                    w_state_nxt  = S_EMPTY;
                    w_clear_main = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and storage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_live      <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;

            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end else if (w_clear_main) begin
                r_main_ctrl <= '0;
                if (c_CLEAR_DATA) begin
                    r_main_data <= '0;
                end
            end

            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire
